// File: rtl/ddr_stream_writer_if.sv
// Stream-in / native-write-out bundle for ddr_stream_writer.
// master = the writer itself, slave = stream source plus controller side.
interface ddr_stream_writer_if #(
  parameter int IN_WIDTH   = 32,
  parameter int DATA_WIDTH = 128,
  parameter int DM_WIDTH   = 16
);
  logic [IN_WIDTH-1:0]   s_data;
  logic                  s_valid;
  logic                  s_last;
  logic                  s_ready;
  logic                  wr_en;
  logic [31:0]           wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [DM_WIDTH-1:0]   wr_datamask;
  logic                  wr_busy;
  logic                  wr_ack;

  modport master (
    input  s_data, s_valid, s_last,
    input  wr_busy, wr_ack,
    output s_ready,
    output wr_en, wr_addr, wr_data, wr_datamask
  );

  modport slave (
    output s_data, s_valid, s_last,
    output wr_busy, wr_ack,
    input  s_ready,
    input  wr_en, wr_addr, wr_data, wr_datamask
  );
endinterface

// File: rtl/ddr_stream_writer.sv
// Packs a narrow stream into native write beats, buffers them,
// and issues them to the DDR controller write port.
module ddr_stream_writer #(
  parameter int          IN_WIDTH   = 32,
  parameter int          DATA_WIDTH = 128,
  parameter int          DM_WIDTH   = 16,
  parameter logic [31:0] START_ADDR = 32'h0000000,
  parameter logic [31:0] END_ADDR   = 32'h1ffffff,
  parameter int          ADDR_STEP  = 16,
  parameter int          FIFO_DEPTH = 16
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        cal_done,
  ddr_stream_writer_if.master         bus,
  output logic                        frame_done,
  output logic                        wrap,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

  localparam int WORDS = DATA_WIDTH / IN_WIDTH;
  localparam int BPW   = IN_WIDTH / 8;
  localparam int IW    = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int LW    = AW + 1;

  typedef enum logic {IDLE, REQ} state_t;

  state_t state;
  state_t state_nxt;

  logic [IW-1:0]         idx;
  logic [DATA_WIDTH-1:0] pack_data;
  logic [DM_WIDTH-1:0]   pack_mask;
  logic [DATA_WIDTH-1:0] beat_data;
  logic [DM_WIDTH-1:0]   beat_mask;
  logic                  ready_q;
  logic                  accept;
  logic                  push;
  logic                  do_push;

  logic [DATA_WIDTH-1:0] mem_data [FIFO_DEPTH];
  logic [DM_WIDTH-1:0]   mem_mask [FIFO_DEPTH];
  logic                  mem_last [FIFO_DEPTH];
  logic [AW-1:0]         wptr;
  logic [AW-1:0]         rptr;
  logic [AW-1:0]         rptr_nxt;
  logic [AW-1:0]         load_ptr;
  logic [LW-1:0]         count;
  logic                  full;
  logic                  empty;

  logic                  can_issue;
  logic                  launch;
  logic                  chain;
  logic                  pop;
  logic                  load;
  logic                  req_en;

  logic [31:0]           addr_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [DM_WIDTH-1:0]   mask_q;
  logic [32:0]           step33;
  logic                  wrap_hit;
  logic [31:0]           addr_nxt;

  assign full     = (count == LW'(FIFO_DEPTH));
  assign empty    = (count == '0);
  assign rptr_nxt = rptr + AW'(1);

  assign accept   = bus.s_valid & bus.s_ready;
  assign push     = accept & ((idx == IW'(WORDS - 1)) | bus.s_last);
  assign do_push  = push & (!full | pop);

  assign bus.s_ready     = ready_q & !full;
  assign bus.wr_en       = req_en;
  assign bus.wr_addr     = addr_q;
  assign bus.wr_data     = data_q;
  assign bus.wr_datamask = mask_q;
  assign fifo_level      = count;

  // merge the incoming word into the partially built beat
  always_comb begin
    beat_data = pack_data;
    beat_mask = pack_mask;
    beat_data[idx*IN_WIDTH +: IN_WIDTH] = bus.s_data;
    beat_mask[idx*BPW +: BPW] = '0;
  end

  // ready stays low while in reset, then follows FIFO space
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) ready_q <= 1'b0;
    else          ready_q <= 1'b1;
  end

  // packer: fill slots, restart after each pushed beat
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx       <= '0;
      pack_data <= '0;
      pack_mask <= '1;
    end else if (accept) begin
      if (push) begin
        idx       <= '0;
        pack_data <= '0;
        pack_mask <= '1;
      end else begin
        idx       <= idx + IW'(1);
        pack_data <= beat_data;
        pack_mask <= beat_mask;
      end
    end
  end

  // beat storage; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_data[wptr] <= beat_data;
      mem_mask[wptr] <= beat_mask;
      mem_last[wptr] <= bus.s_last;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (pop)     rptr <= rptr_nxt;
      unique case ({do_push, pop})
        2'b10:   count <= count + LW'(1);
        2'b01:   count <= count - LW'(1);
        default: count <= count;
      endcase
    end
  end

  // issue FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // issue FSM next state
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (launch)       state_nxt = REQ;
      REQ:  if (pop && !chain) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  // issue FSM outputs; busy only gates new launches
  always_comb begin
    can_issue = cal_done & !bus.wr_busy;
    req_en    = (state == REQ);
    pop       = req_en & bus.wr_ack;
    launch    = (state == IDLE) & can_issue & !empty;
    chain     = pop & can_issue & (count > LW'(1));
    load      = launch | chain;
    load_ptr  = launch ? rptr : rptr_nxt;
  end

  // next address with 33-bit wrap test
  always_comb begin
    step33   = {1'b0, addr_q} + 33'(ADDR_STEP);
    wrap_hit = (step33 + 33'(ADDR_STEP) - 33'd1) > {1'b0, END_ADDR};
    addr_nxt = wrap_hit ? START_ADDR : step33[31:0];
  end

  // hold request payload stable until the next load
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q <= '0;
      mask_q <= '1;
    end else if (load) begin
      data_q <= mem_data[load_ptr];
      mask_q <= mem_mask[load_ptr];
    end
  end

  // address advance and acknowledge-side pulses
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_q     <= START_ADDR;
      wrap       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      wrap       <= 1'b0;
      frame_done <= 1'b0;
      if (pop) begin
        addr_q     <= addr_nxt;
        wrap       <= wrap_hit;
        frame_done <= mem_last[rptr];
      end
    end
  end

endmodule

// File: tb/tb_ddr_stream_writer.sv
// Directed bench: default instance for pack/flush/backpressure/reset,
// small instance (depth 4, 64-byte region) for full and wrap.
module tb_ddr_stream_writer;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic cal_a = 1'b0;
  logic cal_b = 1'b0;
  logic fd_a, wrap_a, fd_b, wrap_b;
  logic [4:0] lvl_a;
  logic [2:0] lvl_b;

  int ntot = 0;
  int npass = 0;
  int en_cnt_a = 0;
  int wrap_cnt_b = 0;

  always #5 clk = ~clk;

  ddr_stream_writer_if a ();
  ddr_stream_writer_if b ();

  ddr_stream_writer u_a (
    .clk(clk), .reset_n(reset_n), .cal_done(cal_a), .bus(a),
    .frame_done(fd_a), .wrap(wrap_a), .fifo_level(lvl_a)
  );

  ddr_stream_writer #(
    .END_ADDR(32'h3F), .FIFO_DEPTH(4)
  ) u_b (
    .clk(clk), .reset_n(reset_n), .cal_done(cal_b), .bus(b),
    .frame_done(fd_b), .wrap(wrap_b), .fifo_level(lvl_b)
  );

  always @(negedge clk) if (a.wr_en) en_cnt_a++;
  always @(negedge clk) if (wrap_b) wrap_cnt_b++;

  task automatic check(input string tag,
                       input logic [127:0] obs,
                       input logic [127:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: got %h want %h", tag, obs, exp);
  endtask

  task automatic send_a(input logic [31:0] d, input logic l);
    a.s_data = d; a.s_valid = 1'b1; a.s_last = l;
    @(negedge clk);
    a.s_valid = 1'b0; a.s_last = 1'b0;
  endtask

  task automatic send_b(input logic [31:0] d, input logic l);
    b.s_data = d; b.s_valid = 1'b1; b.s_last = l;
    @(negedge clk);
    b.s_valid = 1'b0; b.s_last = 1'b0;
  endtask

  function automatic logic [127:0] beat4(input logic [31:0] base);
    return {base + 32'd3, base + 32'd2, base + 32'd1, base};
  endfunction

  initial begin
    int e0;
    int acc;
    logic rdy;
    a.s_data = '0; a.s_valid = 0; a.s_last = 0;
    a.wr_busy = 0; a.wr_ack = 0;
    b.s_data = '0; b.s_valid = 0; b.s_last = 0;
    b.wr_busy = 0; b.wr_ack = 0;

    // reset state
    repeat (2) @(negedge clk);
    check("rst_wr_en", a.wr_en, 0);
    check("rst_addr", a.wr_addr, 0);
    check("rst_mask", a.wr_datamask, 16'hFFFF);
    check("rst_data", a.wr_data, 0);
    check("rst_level", lvl_a, 0);
    check("rst_ready", a.s_ready, 0);
    check("rst_fd", fd_a, 0);
    reset_n = 1'b1;
    @(negedge clk);
    check("ready_after_rst", a.s_ready, 1);

    // pack four words
    cal_a = 1'b1;
    send_a(32'h11111111, 0);
    send_a(32'h22222222, 0);
    send_a(32'h33333333, 0);
    send_a(32'h44444444, 0);
    check("pack_level", lvl_a, 1);
    @(negedge clk);
    check("pack_wr_en", a.wr_en, 1);
    check("pack_data", a.wr_data,
          128'h44444444_33333333_22222222_11111111);
    check("pack_mask", a.wr_datamask, 16'h0000);
    check("pack_addr", a.wr_addr, 32'h0);
    a.wr_ack = 1'b1;
    @(negedge clk);
    a.wr_ack = 1'b0;
    check("pack_en_low", a.wr_en, 0);
    check("pack_addr_adv", a.wr_addr, 32'h10);
    check("pack_level0", lvl_a, 0);
    check("pack_no_fd", fd_a, 0);

    // partial flush on s_last
    send_a(32'hAAAAAAAA, 0);
    send_a(32'hBBBBBBBB, 1);
    @(negedge clk);
    check("part_wr_en", a.wr_en, 1);
    check("part_mask", a.wr_datamask, 16'hFF00);
    check("part_data", a.wr_data,
          {64'h0, 64'hBBBBBBBB_AAAAAAAA});
    check("part_addr", a.wr_addr, 32'h10);
    a.wr_ack = 1'b1;
    @(negedge clk);
    a.wr_ack = 1'b0;
    check("part_fd", fd_a, 1);
    @(negedge clk);
    check("part_fd_pulse", fd_a, 0);

    // backpressure: busy holds everything in the FIFO
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("bp_addr_rst", a.wr_addr, 32'h0);
    a.wr_busy = 1'b1;
    e0 = en_cnt_a;
    for (int i = 0; i < 20; i++) send_a(32'h100 + 32'(i), 0);
    check("bp_level", lvl_a, 5);
    check("bp_ready", a.s_ready, 1);
    check("bp_no_en", en_cnt_a - e0, 0);
    a.wr_busy = 1'b0;
    @(negedge clk);
    check("bp_en", a.wr_en, 1);
    check("bp_addr0", a.wr_addr, 32'h0);
    check("bp_data0", a.wr_data, beat4(32'h100));
    a.wr_ack = 1'b1;
    for (int j = 1; j < 5; j++) begin
      @(negedge clk);
      check("bp_b2b_en", a.wr_en, 1);
      check("bp_addr", a.wr_addr, 32'(16 * j));
      check("bp_data", a.wr_data, beat4(32'h100 + 32'(4 * j)));
    end
    @(negedge clk);
    a.wr_ack = 1'b0;
    check("bp_done_en", a.wr_en, 0);
    check("bp_done_lvl", lvl_a, 0);
    check("bp_done_addr", a.wr_addr, 32'h50);

    // full: depth 4, no acks
    cal_b = 1'b1;
    acc = 0;
    for (int i = 0; i < 24; i++) begin
      rdy = b.s_ready;
      b.s_data = 32'h200 + 32'(acc);
      b.s_valid = 1'b1;
      @(negedge clk);
      if (rdy) acc++;
    end
    b.s_valid = 1'b0;
    check("full_accepted", acc, 16);
    check("full_ready", b.s_ready, 0);
    check("full_level", lvl_b, 4);
    check("full_wr_en", b.wr_en, 1);

    // drain with single acks; region wraps after 4th beat
    for (int j = 0; j < 4; j++) begin
      check("drain_data", b.wr_data, beat4(32'h200 + 32'(4 * j)));
      check("drain_addr", b.wr_addr, 32'(16 * j));
      b.wr_ack = 1'b1;
      @(negedge clk);
      b.wr_ack = 1'b0;
      check("drain_wrap", wrap_b, (j == 3));
    end
    check("drain_idle", b.wr_en, 0);
    check("wrap_addr", b.wr_addr, 32'h0);
    check("drain_level", lvl_b, 0);
    send_b(32'h300, 0);
    send_b(32'h301, 0);
    send_b(32'h302, 0);
    send_b(32'h303, 0);
    @(negedge clk);
    check("wrap5_en", b.wr_en, 1);
    check("wrap5_addr", b.wr_addr, 32'h0);
    check("wrap5_data", b.wr_data, beat4(32'h300));
    b.wr_ack = 1'b1;
    @(negedge clk);
    b.wr_ack = 1'b0;
    check("wrap5_nowrap", wrap_b, 0);
    check("wrap_once", wrap_cnt_b, 1);
    check("wrap5_next", b.wr_addr, 32'h10);

    // reset while a request is pending
    send_a(32'h400, 0);
    send_a(32'h401, 0);
    send_a(32'h402, 0);
    send_a(32'h403, 0);
    @(negedge clk);
    check("mid_en", a.wr_en, 1);
    check("mid_addr", a.wr_addr, 32'h50);
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_en", a.wr_en, 0);
    check("mid_rst_lvl", lvl_a, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("mid_rel_addr", a.wr_addr, 32'h0);
    check("mid_rel_en", a.wr_en, 0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
